class_clause_data: RTL and testbench

- Synthesizable capture/decode block for bin-manager debug and checking.
- Latches one packed clause, one packed var-state list and one packed lvl-state list, as driven towards update_bin.
- Exposes per-entry decoded fields selected by index, plus registered summary statistics.
- Sits beside the bin manager as a monitor. It has no side effects on the datapath.

---
 rtl/class_clause_data_if.sv | 52 +++++
 rtl/class_clause_data.sv | 130 +++++++++++++
 tb/tb_class_clause_data.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/class_clause_data_if.sv
// Bundles the capture strobes, packed lists, index selects and decoded/summary
// outputs of class_clause_data; the master drives lists, the slave is the monitor.
interface class_clause_data_if #(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int WIDTH_LVL_STATES = 30,
  parameter int IDX_WIDTH        = 3
) ();
  logic                                   set_clause_i;
  logic [NUM_VARS*2-1:0]                  clause_i;
  logic                                   set_vs_i;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   var_state_i;
  logic                                   set_ls_i;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i;
  logic [IDX_WIDTH-1:0]                   lit_idx_i;
  logic [IDX_WIDTH-1:0]                   lvl_idx_i;

  logic                                   clause_valid_o;
  logic                                   vs_valid_o;
  logic                                   ls_valid_o;
  logic [1:0]                             lit_o;
  logic [IDX_WIDTH:0]                     lit_cnt_o;
  logic [IDX_WIDTH:0]                     pos_cnt_o;
  logic [IDX_WIDTH:0]                     neg_cnt_o;
  logic [1:0]                             vs_value_o;
  logic                                   vs_implied_o;
  logic [WIDTH_LVL-1:0]                   vs_level_o;
  logic [IDX_WIDTH:0]                     vs_assigned_cnt_o;
  logic [WIDTH_LVL-1:0]                   vs_max_level_o;
  logic [WIDTH_BIN_ID-1:0]                ls_dcd_bin_o;
  logic                                   ls_has_bkt_o;
  logic [IDX_WIDTH:0]                     ls_bkt_cnt_o;

  modport master (
    output set_clause_i, clause_i, set_vs_i, var_state_i, set_ls_i, lvl_states_i,
           lit_idx_i, lvl_idx_i,
    input  clause_valid_o, vs_valid_o, ls_valid_o, lit_o, lit_cnt_o, pos_cnt_o,
           neg_cnt_o, vs_value_o, vs_implied_o, vs_level_o, vs_assigned_cnt_o,
           vs_max_level_o, ls_dcd_bin_o, ls_has_bkt_o, ls_bkt_cnt_o
  );

  modport slave (
    input  set_clause_i, clause_i, set_vs_i, var_state_i, set_ls_i, lvl_states_i,
           lit_idx_i, lvl_idx_i,
    output clause_valid_o, vs_valid_o, ls_valid_o, lit_o, lit_cnt_o, pos_cnt_o,
           neg_cnt_o, vs_value_o, vs_implied_o, vs_level_o, vs_assigned_cnt_o,
           vs_max_level_o, ls_dcd_bin_o, ls_has_bkt_o, ls_bkt_cnt_o
  );
endinterface

// File: rtl/class_clause_data.sv
// Monitor that latches a clause, var-state list and lvl-state list heading to
// update_bin, decodes one entry of each by index and registers summary counts.
module class_clause_data #(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int WIDTH_LVL_STATES = 30,
  parameter int IDX_WIDTH        = 3
) (
  input logic               clk,
  input logic               rst,
  class_clause_data_if.slave bus
);
  localparam logic [IDX_WIDTH:0] CNT_ONE = 1;

  logic [NUM_VARS*2-1:0]                clause_q;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_q;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_q;
  logic                                 clause_valid_q, vs_valid_q, ls_valid_q;

  logic [IDX_WIDTH:0]   lit_cnt_d, pos_cnt_d, neg_cnt_d, asg_cnt_d, bkt_cnt_d;
  logic [IDX_WIDTH:0]   lit_cnt_q, pos_cnt_q, neg_cnt_q, asg_cnt_q, bkt_cnt_q;
  logic [WIDTH_LVL-1:0] max_lvl_d, max_lvl_q;

  logic [1:0]              lit_sel, val_sel;
  logic                    imp_sel, bkt_sel;
  logic [WIDTH_LVL-1:0]    lvl_sel;
  logic [WIDTH_BIN_ID-1:0] dcd_sel;

  // Summary next-state: pure function of the stored lists
  always_comb begin
    lit_cnt_d = '0;
    pos_cnt_d = '0;
    neg_cnt_d = '0;
    asg_cnt_d = '0;
    bkt_cnt_d = '0;
    max_lvl_d = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (clause_q[2*k +: 2] != 2'b00) lit_cnt_d = lit_cnt_d + CNT_ONE;
      if (clause_q[2*k +: 2] == 2'b01) pos_cnt_d = pos_cnt_d + CNT_ONE;
      if (clause_q[2*k +: 2] == 2'b10) neg_cnt_d = neg_cnt_d + CNT_ONE;
      if (vs_q[k*WIDTH_VAR_STATES + WIDTH_LVL + 1 +: 2] != 2'b00) begin
        asg_cnt_d = asg_cnt_d + CNT_ONE;
        if (vs_q[k*WIDTH_VAR_STATES +: WIDTH_LVL] > max_lvl_d)
          max_lvl_d = vs_q[k*WIDTH_VAR_STATES +: WIDTH_LVL];
      end
    end
    for (int k = 0; k < NUM_LVLS; k++) begin
      if (ls_q[k*WIDTH_LVL_STATES]) bkt_cnt_d = bkt_cnt_d + CNT_ONE;
    end
  end

  // Indexed decode; unmatched (out-of-range) indices fall through to zero
  always_comb begin
    lit_sel = '0;
    val_sel = '0;
    imp_sel = 1'b0;
    lvl_sel = '0;
    dcd_sel = '0;
    bkt_sel = 1'b0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (int'(bus.lit_idx_i) == k) begin
        lit_sel = clause_q[2*k +: 2];
        lvl_sel = vs_q[k*WIDTH_VAR_STATES +: WIDTH_LVL];
        imp_sel = vs_q[k*WIDTH_VAR_STATES + WIDTH_LVL];
        val_sel = vs_q[k*WIDTH_VAR_STATES + WIDTH_LVL + 1 +: 2];
      end
    end
    for (int k = 0; k < NUM_LVLS; k++) begin
      if (int'(bus.lvl_idx_i) == k) begin
        bkt_sel = ls_q[k*WIDTH_LVL_STATES];
        dcd_sel = ls_q[k*WIDTH_LVL_STATES + 1 +: WIDTH_BIN_ID];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clause_q       <= '0;
      vs_q           <= '0;
      ls_q           <= '0;
      clause_valid_q <= 1'b0;
      vs_valid_q     <= 1'b0;
      ls_valid_q     <= 1'b0;
      lit_cnt_q      <= '0;
      pos_cnt_q      <= '0;
      neg_cnt_q      <= '0;
      asg_cnt_q      <= '0;
      bkt_cnt_q      <= '0;
      max_lvl_q      <= '0;
    end else begin
      if (bus.set_clause_i) begin
        clause_q       <= bus.clause_i;
        clause_valid_q <= 1'b1;
      end
      if (bus.set_vs_i) begin
        vs_q       <= bus.var_state_i;
        vs_valid_q <= 1'b1;
      end
      if (bus.set_ls_i) begin
        ls_q       <= bus.lvl_states_i;
        ls_valid_q <= 1'b1;
      end
      lit_cnt_q <= lit_cnt_d;
      pos_cnt_q <= pos_cnt_d;
      neg_cnt_q <= neg_cnt_d;
      asg_cnt_q <= asg_cnt_d;
      bkt_cnt_q <= bkt_cnt_d;
      max_lvl_q <= max_lvl_d;
    end
  end

  assign bus.clause_valid_o    = clause_valid_q;
  assign bus.vs_valid_o        = vs_valid_q;
  assign bus.ls_valid_o        = ls_valid_q;
  assign bus.lit_o             = lit_sel;
  assign bus.lit_cnt_o         = lit_cnt_q;
  assign bus.pos_cnt_o         = pos_cnt_q;
  assign bus.neg_cnt_o         = neg_cnt_q;
  assign bus.vs_value_o        = val_sel;
  assign bus.vs_implied_o      = imp_sel;
  assign bus.vs_level_o        = lvl_sel;
  assign bus.vs_assigned_cnt_o = asg_cnt_q;
  assign bus.vs_max_level_o    = max_lvl_q;
  assign bus.ls_dcd_bin_o      = dcd_sel;
  assign bus.ls_has_bkt_o      = bkt_sel;
  assign bus.ls_bkt_cnt_o      = bkt_cnt_q;
endmodule

// File: tb/tb_class_clause_data.sv
// Directed bench for class_clause_data: vector table for capture/decode plus
// hand sequences for summary latency, simultaneous strobes and reset priority.
module tb_class_clause_data;
  localparam int NV = 8, NL = 8, WL = 16, WB = 10, WVS = 30, WLS = 30, IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  class_clause_data_if #(.NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
    .WIDTH_BIN_ID(WB), .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS),
    .IDX_WIDTH(IW)) bus ();

  class_clause_data #(.NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
    .WIDTH_BIN_ID(WB), .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS),
    .IDX_WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        sc, sv, sl;
    logic [15:0] clause;
    logic [2:0]  li, vi;
    logic        cv, vv, lv;
    logic [1:0]  lit;
    logic [3:0]  lc, pc, nc;
    logic [1:0]  val;
    logic        imp;
    logic [15:0] lvl;
    logic [3:0]  ac;
    logic [15:0] ml;
    logic [9:0]  dcd;
    logic        hb;
    logic [3:0]  bc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[9];
  logic [15:0] C;
  logic [WVS*NV-1:0] VS;
  logic [WLS*NL-1:0] LS;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string t, input vec_t v);
    chk({t, " clause_valid"}, 32'(bus.clause_valid_o), 32'(v.cv));
    chk({t, " vs_valid"}, 32'(bus.vs_valid_o), 32'(v.vv));
    chk({t, " ls_valid"}, 32'(bus.ls_valid_o), 32'(v.lv));
    chk({t, " lit"}, 32'(bus.lit_o), 32'(v.lit));
    chk({t, " lit_cnt"}, 32'(bus.lit_cnt_o), 32'(v.lc));
    chk({t, " pos_cnt"}, 32'(bus.pos_cnt_o), 32'(v.pc));
    chk({t, " neg_cnt"}, 32'(bus.neg_cnt_o), 32'(v.nc));
    chk({t, " vs_value"}, 32'(bus.vs_value_o), 32'(v.val));
    chk({t, " vs_implied"}, 32'(bus.vs_implied_o), 32'(v.imp));
    chk({t, " vs_level"}, 32'(bus.vs_level_o), 32'(v.lvl));
    chk({t, " vs_assigned_cnt"}, 32'(bus.vs_assigned_cnt_o), 32'(v.ac));
    chk({t, " vs_max_level"}, 32'(bus.vs_max_level_o), 32'(v.ml));
    chk({t, " ls_dcd_bin"}, 32'(bus.ls_dcd_bin_o), 32'(v.dcd));
    chk({t, " ls_has_bkt"}, 32'(bus.ls_has_bkt_o), 32'(v.hb));
    chk({t, " ls_bkt_cnt"}, 32'(bus.ls_bkt_cnt_o), 32'(v.bc));
  endtask

  task automatic check_zero(input string t);
    vec_t z;
    z = '{1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0,
          4'd0, 2'd0, 1'b0, 16'd0, 4'd0, 16'd0, 10'd0, 1'b0, 4'd0};
    check_vec(t, z);
  endtask

  task automatic set_strobes(input logic c, input logic v, input logic l);
    bus.set_clause_i = c;
    bus.set_vs_i     = v;
    bus.set_ls_i     = l;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    C  = 16'b00_10_00_01_01_00_11_10;
    VS = '0;
    VS[3*WVS +: WVS] = 30'h0003_0007;                       // value 01, implied, level 7
    VS[5*WVS +: WVS] = 30'h0004_000C;                       // value 10, level 12
    VS[7*WVS +: WVS] = 30'h2001_0064;                       // free, implied, level 100, junk bit 29
    LS = '0;
    LS[0*WLS +: WLS] = 30'd19;                              // dcd_bin 9, has_bkt
    LS[6*WLS +: WLS] = 30'd19;
    LS[3*WLS +: WLS] = 30'h0010_0000;                       // only ignored upper bits set

    //          sc    sv    sl    clause li    vi    cv    vv    lv    lit   lc    pc    nc    val   imp   lvl      ac    ml       dcd    hb    bc
    tbl[0] = '{1'b1, 1'b0, 1'b0, C, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd0, 16'd0,  10'd0, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, C, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd0, 16'd0,  10'd0, 1'b0, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, C, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd0, 16'd0,  10'd0, 1'b0, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, C, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd5, 4'd2, 4'd2, 2'd1, 1'b1, 16'd7,   4'd2, 16'd12, 10'd0, 1'b0, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, C, 3'd5, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd5, 4'd2, 4'd2, 2'd2, 1'b0, 16'd12,  4'd2, 16'd12, 10'd0, 1'b0, 4'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, C, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd5, 4'd2, 4'd2, 2'd0, 1'b1, 16'd100, 4'd2, 16'd12, 10'd0, 1'b0, 4'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, C, 3'd0, 3'd6, 1'b1, 1'b1, 1'b1, 2'd2, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd2, 16'd12, 10'd9, 1'b1, 4'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, C, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd2, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd2, 16'd12, 10'd0, 1'b0, 4'd2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, C, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 2'd2, 4'd5, 4'd2, 4'd2, 2'd0, 1'b0, 16'd0,   4'd2, 16'd12, 10'd9, 1'b1, 4'd2};

    // Reset wins over a simultaneous clause strobe
    rst = 1'b1;
    set_strobes(1'b1, 1'b0, 1'b0);
    bus.clause_i     = C;
    bus.var_state_i  = VS;
    bus.lvl_states_i = LS;
    bus.lit_idx_i    = '0;
    bus.lvl_idx_i    = '0;
    step();
    rst = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0);
    check_zero("reset");

    foreach (tbl[i]) begin
      set_strobes(tbl[i].sc, tbl[i].sv, tbl[i].sl);
      bus.clause_i  = tbl[i].clause;
      bus.lit_idx_i = tbl[i].li;
      bus.lvl_idx_i = tbl[i].vi;
      step();
      step();
      set_strobes(1'b0, 1'b0, 1'b0);
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Summary lags the stored clause by one edge
    bus.lit_idx_i = 3'd0;
    bus.lvl_idx_i = 3'd0;
    bus.clause_i  = 16'hFFFF;
    set_strobes(1'b1, 1'b0, 1'b0);
    step();
    set_strobes(1'b0, 1'b0, 1'b0);
    chk("lat lit", 32'(bus.lit_o), 32'd3);
    chk("lat lit_cnt old", 32'(bus.lit_cnt_o), 32'd5);
    chk("lat pos_cnt old", 32'(bus.pos_cnt_o), 32'd2);
    step();
    chk("lat lit_cnt new", 32'(bus.lit_cnt_o), 32'd8);
    chk("lat pos_cnt new", 32'(bus.pos_cnt_o), 32'd0);
    chk("lat neg_cnt new", 32'(bus.neg_cnt_o), 32'd0);

    // Recapture as all-zero clause
    bus.clause_i = 16'h0000;
    set_strobes(1'b1, 1'b0, 1'b0);
    step();
    set_strobes(1'b0, 1'b0, 1'b0);
    step();
    chk("zero lit_cnt", 32'(bus.lit_cnt_o), 32'd0);
    chk("zero lit", 32'(bus.lit_o), 32'd0);
    chk("zero clause_valid", 32'(bus.clause_valid_o), 32'd1);
    chk("zero vs_assigned kept", 32'(bus.vs_assigned_cnt_o), 32'd2);

    // Mid-operation reset with every strobe high
    rst = 1'b1;
    bus.clause_i = C;
    set_strobes(1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0);
    bus.lvl_idx_i = 3'd6;
    #1;
    check_zero("midreset");

    // Simultaneous strobes: all valids on the same edge, counts one edge later
    bus.lit_idx_i = 3'd0;
    bus.lvl_idx_i = 3'd6;
    set_strobes(1'b1, 1'b1, 1'b1);
    step();
    set_strobes(1'b0, 1'b0, 1'b0);
    chk("sim clause_valid", 32'(bus.clause_valid_o), 32'd1);
    chk("sim vs_valid", 32'(bus.vs_valid_o), 32'd1);
    chk("sim ls_valid", 32'(bus.ls_valid_o), 32'd1);
    chk("sim lit", 32'(bus.lit_o), 32'd2);
    chk("sim dcd", 32'(bus.ls_dcd_bin_o), 32'd9);
    chk("sim lit_cnt early", 32'(bus.lit_cnt_o), 32'd0);
    step();
    chk("sim lit_cnt", 32'(bus.lit_cnt_o), 32'd5);
    chk("sim neg_cnt", 32'(bus.neg_cnt_o), 32'd2);
    chk("sim vs_assigned", 32'(bus.vs_assigned_cnt_o), 32'd2);
    chk("sim vs_max_level", 32'(bus.vs_max_level_o), 32'd12);
    chk("sim bkt_cnt", 32'(bus.ls_bkt_cnt_o), 32'd2);

    // Final reset pulse clears everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.lit_idx_i = 3'd3;
    bus.lvl_idx_i = 3'd0;
    #1;
    check_zero("final reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
